// File: rtl/cmd_frame_if.sv
// Signal bundle between cmd_frame_ctrl and the UART FIFO / register file / ALU side.
interface cmd_frame_if #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH  = 4,
  parameter int unsigned ALU_WIDTH   = 16,
  parameter int unsigned ALUFN_WIDTH = 4
) ();
  logic [DATA_WIDTH-1:0]  RX_P_Data;
  logic                   RX_D_VLD;
  logic [DATA_WIDTH-1:0]  RdData;
  logic                   RdData_Valid;
  logic [ALU_WIDTH-1:0]   ALU_OUT;
  logic                   OUT_Valid;
  logic                   FIFO_FULL;
  logic [ADDR_WIDTH-1:0]  Address;
  logic                   WrEn;
  logic                   RdEn;
  logic [DATA_WIDTH-1:0]  WrData;
  logic                   ALU_EN;
  logic [ALUFN_WIDTH-1:0] ALU_FUN;
  logic                   CLK_EN;
  logic [DATA_WIDTH-1:0]  TX_P_Data;
  logic                   TX_D_VLD;
  logic                   Busy;
  logic                   Frame_Err;

  modport master (
    input  RX_P_Data, RX_D_VLD, RdData, RdData_Valid, ALU_OUT, OUT_Valid, FIFO_FULL,
    output Address, WrEn, RdEn, WrData, ALU_EN, ALU_FUN, CLK_EN,
           TX_P_Data, TX_D_VLD, Busy, Frame_Err
  );

  modport slave (
    output RX_P_Data, RX_D_VLD, RdData, RdData_Valid, ALU_OUT, OUT_Valid, FIFO_FULL,
    input  Address, WrEn, RdEn, WrData, ALU_EN, ALU_FUN, CLK_EN,
           TX_P_Data, TX_D_VLD, Busy, Frame_Err
  );
endinterface

// File: rtl/cmd_frame_ctrl.sv
// UART command-frame controller: decodes RX byte frames into register-file
// writes, burst reads and ALU operations, and returns results to the TX FIFO.
module cmd_frame_ctrl #(
  parameter int unsigned           DATA_WIDTH     = 8,
  parameter int unsigned           ADDR_WIDTH     = 4,
  parameter int unsigned           ALU_WIDTH      = 16,
  parameter int unsigned           ALUFN_WIDTH    = 4,
  parameter int unsigned           BURST_MAX      = 8,
  parameter int unsigned           TIMEOUT_CYCLES = 1023,
  parameter logic [DATA_WIDTH-1:0] ERR_BYTE       = 'hFF
) (
  input logic         CLK,
  input logic         RST,
  cmd_frame_if.master bus
);
  localparam int unsigned RES_BYTES = ALU_WIDTH / DATA_WIDTH;
  localparam int unsigned TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned IDX_W     = $clog2(RES_BYTES) + 1;

  localparam logic [DATA_WIDTH-1:0] CMD_WR    = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] CMD_RD    = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU2  = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU0  = DATA_WIDTH'(8'hDD);
  localparam logic [DATA_WIDTH-1:0] CMD_BURST = DATA_WIDTH'(8'hEE);

  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_CNT, RD_REQ, RD_WAIT, RD_TX,
    ALU_A, ALU_B, ALU_FUN, ALU_WAIT, ALU_TX, ERR_TX
  } state_t;

  state_t state, state_n;

  logic [ADDR_WIDTH-1:0]  addr_q, addr_n, ptr_q, ptr_n;
  logic [DATA_WIDTH-1:0]  wr_data_q, wr_data_n, tx_data_q, tx_data_n, rd_buf_q, rd_buf_n;
  logic [DATA_WIDTH-1:0]  cnt_q, cnt_n;
  logic [ALUFN_WIDTH-1:0] alu_fun_q, alu_fun_n;
  logic [ALU_WIDTH-1:0]   res_q, res_n;
  logic [IDX_W-1:0]       idx_q, idx_n;
  logic [TMO_W-1:0]       tmo_q, tmo_n;
  logic wr_en_q, wr_en_n, rd_en_q, rd_en_n, tx_vld_q, tx_vld_n;
  logic alu_en_q, alu_en_n, busy_q, busy_n, ferr_q, ferr_n, burst_q, burst_n;

  logic                  rx, rx_state, tmo_run, tmo_hit, cnt_bad, cnt_last, res_last, full;
  logic [DATA_WIDTH-1:0] rx_byte;

  assign rx       = bus.RX_D_VLD;
  assign rx_byte  = bus.RX_P_Data;
  assign full     = bus.FIFO_FULL;
  assign rx_state = state inside {WR_ADDR, WR_DATA, RD_ADDR, RD_CNT, ALU_A, ALU_B, ALU_FUN};
  assign tmo_run  = rx_state || (state inside {RD_WAIT, ALU_WAIT});
  assign tmo_hit  = tmo_q == TMO_W'(TIMEOUT_CYCLES - 1);
  assign cnt_bad  = (rx_byte == '0) || (rx_byte > DATA_WIDTH'(BURST_MAX));
  assign cnt_last = cnt_q == DATA_WIDTH'(1);
  assign res_last = idx_q == IDX_W'(RES_BYTES - 1);

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_n;
  end

  // A byte or data-valid in the same cycle as the timeout wins over the timeout.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     if (rx) begin
                  if (rx_byte == CMD_WR)                               state_n = WR_ADDR;
                  else if (rx_byte == CMD_RD || rx_byte == CMD_BURST) state_n = RD_ADDR;
                  else if (rx_byte == CMD_ALU2)                        state_n = ALU_A;
                  else if (rx_byte == CMD_ALU0)                        state_n = ALU_FUN;
                  else                                                 state_n = ERR_TX;
                end
      WR_ADDR:  if (rx) state_n = WR_DATA;                      else if (tmo_hit) state_n = ERR_TX;
      WR_DATA:  if (rx) state_n = IDLE;                         else if (tmo_hit) state_n = ERR_TX;
      RD_ADDR:  if (rx) state_n = burst_q ? RD_CNT : RD_REQ;    else if (tmo_hit) state_n = ERR_TX;
      RD_CNT:   if (rx) state_n = cnt_bad ? ERR_TX : RD_REQ;    else if (tmo_hit) state_n = ERR_TX;
      RD_REQ:   state_n = RD_WAIT;
      RD_WAIT:  if (bus.RdData_Valid) state_n = RD_TX;          else if (tmo_hit) state_n = ERR_TX;
      RD_TX:    if (!full) state_n = cnt_last ? IDLE : RD_REQ;
      ALU_A:    if (rx) state_n = ALU_B;                        else if (tmo_hit) state_n = ERR_TX;
      ALU_B:    if (rx) state_n = ALU_FUN;                      else if (tmo_hit) state_n = ERR_TX;
      ALU_FUN:  if (rx) state_n = ALU_WAIT;                     else if (tmo_hit) state_n = ERR_TX;
      ALU_WAIT: if (bus.OUT_Valid) state_n = ALU_TX;            else if (tmo_hit) state_n = ERR_TX;
      ALU_TX:   if (!full && res_last) state_n = IDLE;
      ERR_TX:   if (!full) state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  always_comb begin
    wr_en_n   = 1'b0;
    rd_en_n   = 1'b0;
    tx_vld_n  = 1'b0;
    ferr_n    = 1'b0;
    addr_n    = addr_q;
    wr_data_n = wr_data_q;
    tx_data_n = tx_data_q;
    alu_en_n  = alu_en_q;
    alu_fun_n = alu_fun_q;
    ptr_n     = ptr_q;
    cnt_n     = cnt_q;
    burst_n   = burst_q;
    rd_buf_n  = rd_buf_q;
    res_n     = res_q;
    idx_n     = idx_q;
    busy_n    = state_n != IDLE;
    tmo_n     = tmo_run ? tmo_q + TMO_W'(1) : tmo_q;
    if ((state_n != state) || (rx && rx_state)) tmo_n = '0;

    case (state)
      IDLE:     if (rx) burst_n = rx_byte == CMD_BURST;
      WR_ADDR:  if (rx) ptr_n = rx_byte[ADDR_WIDTH-1:0];
      WR_DATA:  if (rx) begin
                  wr_en_n   = 1'b1;
                  addr_n    = ptr_q;
                  wr_data_n = rx_byte;
                end
      RD_ADDR:  if (rx) begin
                  ptr_n = rx_byte[ADDR_WIDTH-1:0];
                  if (!burst_q) cnt_n = DATA_WIDTH'(1);
                end
      RD_CNT:   if (rx && !cnt_bad) cnt_n = rx_byte;
      RD_REQ:   begin
                  rd_en_n = 1'b1;
                  addr_n  = ptr_q;
                end
      RD_WAIT:  if (bus.RdData_Valid) rd_buf_n = bus.RdData;
      RD_TX:    if (!full) begin
                  tx_vld_n  = 1'b1;
                  tx_data_n = rd_buf_q;
                  ptr_n     = ptr_q + ADDR_WIDTH'(1);
                  cnt_n     = cnt_q - DATA_WIDTH'(1);
                end
      ALU_A:    if (rx) begin
                  wr_en_n   = 1'b1;
                  addr_n    = '0;
                  wr_data_n = rx_byte;
                end
      ALU_B:    if (rx) begin
                  wr_en_n   = 1'b1;
                  addr_n    = ADDR_WIDTH'(1);
                  wr_data_n = rx_byte;
                end
      ALU_FUN:  if (rx) begin
                  alu_fun_n = rx_byte[ALUFN_WIDTH-1:0];
                  alu_en_n  = 1'b1;
                end
      ALU_WAIT: if (bus.OUT_Valid) begin
                  res_n = bus.ALU_OUT;
                  idx_n = '0;
                end
      // Result is shifted out LSB first; idx only tracks when the last byte leaves.
      ALU_TX:   if (!full) begin
                  tx_vld_n  = 1'b1;
                  tx_data_n = res_q[DATA_WIDTH-1:0];
                  res_n     = res_q >> DATA_WIDTH;
                  idx_n     = idx_q + IDX_W'(1);
                  if (res_last) alu_en_n = 1'b0;
                end
      ERR_TX:   if (!full) begin
                  tx_vld_n  = 1'b1;
                  tx_data_n = ERR_BYTE;
                end
      default:  ;
    endcase

    if ((state_n == ERR_TX) && (state != ERR_TX)) begin
      ferr_n   = 1'b1;
      alu_en_n = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      addr_q    <= '0;
      wr_data_q <= '0;
      tx_data_q <= '0;
      alu_fun_q <= '0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      tx_vld_q  <= 1'b0;
      alu_en_q  <= 1'b0;
      busy_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      burst_q   <= 1'b0;
      rd_buf_q  <= '0;
      res_q     <= '0;
      idx_q     <= '0;
      tmo_q     <= '0;
    end else begin
      addr_q    <= addr_n;
      wr_data_q <= wr_data_n;
      tx_data_q <= tx_data_n;
      alu_fun_q <= alu_fun_n;
      wr_en_q   <= wr_en_n;
      rd_en_q   <= rd_en_n;
      tx_vld_q  <= tx_vld_n;
      alu_en_q  <= alu_en_n;
      busy_q    <= busy_n;
      ferr_q    <= ferr_n;
      ptr_q     <= ptr_n;
      cnt_q     <= cnt_n;
      burst_q   <= burst_n;
      rd_buf_q  <= rd_buf_n;
      res_q     <= res_n;
      idx_q     <= idx_n;
      tmo_q     <= tmo_n;
    end
  end

  assign bus.Address   = addr_q;
  assign bus.WrEn      = wr_en_q;
  assign bus.RdEn      = rd_en_q;
  assign bus.WrData    = wr_data_q;
  assign bus.ALU_EN    = alu_en_q;
  assign bus.CLK_EN    = alu_en_q;
  assign bus.ALU_FUN   = alu_fun_q;
  assign bus.TX_P_Data = tx_data_q;
  assign bus.TX_D_VLD  = tx_vld_q;
  assign bus.Busy      = busy_q;
  assign bus.Frame_Err = ferr_q;
endmodule

// File: tb/tb_cmd_frame_ctrl.sv
// Scoreboard bench for cmd_frame_ctrl: expected writes, reads and TX bytes are
// queued as frames are driven and popped as the DUT produces them.
module tb_cmd_frame_ctrl;
  localparam int unsigned TMO = 1023;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cmd_frame_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .ALU_WIDTH(16), .ALUFN_WIDTH(4)) bus ();

  cmd_frame_ctrl #(
    .DATA_WIDTH(8), .ADDR_WIDTH(4), .ALU_WIDTH(16), .ALUFN_WIDTH(4),
    .BURST_MAX(8), .TIMEOUT_CYCLES(TMO), .ERR_BYTE(8'hFF)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  int unsigned checks = 0, failures = 0;
  int unsigned tx_seen = 0, ferr_seen = 0, ferr_exp = 0;
  logic [7:0]  tx_q[$];
  logic [11:0] wr_q[$];
  logic [3:0]  rd_q[$];
  logic [7:0]  mem[16];
  logic        ff_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctl"}, 32'({bus.WrEn, bus.RdEn, bus.TX_D_VLD, bus.ALU_EN, bus.CLK_EN,
                              bus.Busy, bus.Frame_Err}), 32'd0);
    check({tag, "_addr"}, 32'(bus.Address), 32'd0);
    check({tag, "_wrdata"}, 32'(bus.WrData), 32'd0);
    check({tag, "_txdata"}, 32'(bus.TX_P_Data), 32'd0);
    check({tag, "_alufun"}, 32'(bus.ALU_FUN), 32'd0);
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.RX_P_Data = b;
    bus.RX_D_VLD  = 1'b1;
    @(negedge clk);
    bus.RX_D_VLD  = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int unsigned budget);
    int unsigned n = 0;
    while (bus.Busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check({tag, "_idle"}, 32'(bus.Busy), 32'd0);
  endtask

  task automatic drained(input string tag);
    check({tag, "_txq"}, 32'(tx_q.size()), 32'd0);
    check({tag, "_wrq"}, 32'(wr_q.size()), 32'd0);
    check({tag, "_rdq"}, 32'(rd_q.size()), 32'd0);
    check({tag, "_ferr"}, ferr_seen, ferr_exp);
  endtask

  task automatic alu_op(input string tag, input bit two_op, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] fun, input logic [15:0] res);
    if (two_op) begin
      wr_q.push_back({4'h0, a});
      wr_q.push_back({4'h1, b});
      send(8'hCC); send(a); send(b);
    end else begin
      send(8'hDD);
    end
    send(fun);
    check({tag, "_fun"}, 32'(bus.ALU_FUN), 32'(fun[3:0]));
    check({tag, "_en"}, 32'({bus.ALU_EN, bus.CLK_EN}), 32'd3);
    tx_q.push_back(res[7:0]);
    tx_q.push_back(res[15:8]);
    repeat (2) @(negedge clk);
    bus.ALU_OUT   = res;
    bus.OUT_Valid = 1'b1;
    @(negedge clk);
    bus.OUT_Valid = 1'b0;
    wait_idle(tag, 50);
    check({tag, "_en_off"}, 32'({bus.ALU_EN, bus.CLK_EN}), 32'd0);
    drained(tag);
  endtask

  task automatic burst(input string tag, input logic [3:0] addr, input int unsigned cnt);
    for (int unsigned i = 0; i < cnt; i++) begin
      rd_q.push_back(4'(addr + 4'(i)));
      tx_q.push_back(mem[4'(addr + 4'(i))]);
    end
    send(8'hEE); send({4'h0, addr}); send(8'(cnt));
    wait_idle(tag, 200);
    drained(tag);
  endtask

  always @(posedge clk) ff_prev <= bus.FIFO_FULL;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.TX_D_VLD) begin
        tx_seen++;
        check("tx_vs_full", 32'(ff_prev), 32'd0);
        check("tx_pending", 32'(tx_q.size() != 0), 32'd1);
        if (tx_q.size() != 0) check("tx_byte", 32'(bus.TX_P_Data), 32'(tx_q.pop_front()));
      end
      if (bus.WrEn) begin
        check("wr_pending", 32'(wr_q.size() != 0), 32'd1);
        if (wr_q.size() != 0) check("wr_addr_data", 32'({bus.Address, bus.WrData}), 32'(wr_q.pop_front()));
      end
      if (bus.RdEn) begin
        check("rd_pending", 32'(rd_q.size() != 0), 32'd1);
        if (rd_q.size() != 0) check("rd_addr", 32'(bus.Address), 32'(rd_q.pop_front()));
      end
      if (bus.Frame_Err) ferr_seen++;
    end
  end

  // Register-file model: answers each RdEn with the stored byte on the next cycle.
  initial begin
    bus.RdData       = '0;
    bus.RdData_Valid = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.RdEn && !rst) begin
        bus.RdData       = mem[bus.Address];
        bus.RdData_Valid = 1'b1;
        @(negedge clk);
        bus.RdData_Valid = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    int unsigned base, n;
    bus.RX_P_Data = '0;
    bus.RX_D_VLD  = 1'b0;
    bus.ALU_OUT   = '0;
    bus.OUT_Valid = 1'b0;
    bus.FIFO_FULL = 1'b0;
    foreach (mem[i]) mem[i] = 8'($urandom);

    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    // plain write with one-cycle latency after the data byte
    wr_q.push_back({4'h5, 8'h3C});
    send(8'hAA); send(8'h05); send(8'h3C);
    check("wr_latency", 32'(bus.WrEn), 32'd1);
    @(negedge clk);
    check("wr_single", 32'(bus.WrEn), 32'd0);
    check("wr_busy", 32'(bus.Busy), 32'd0);
    drained("wr");

    alu_op("alu2", 1'b1, 8'h0A, 8'h03, 8'h00, 16'h010D);
    alu_op("alu0", 1'b0, 8'h00, 8'h00, 8'h05, 16'hBEEF);

    // single read, then burst wrapping E,F,0 with a 5-cycle FIFO stall mid-burst
    rd_q.push_back(4'h7);
    tx_q.push_back(mem[7]);
    send(8'hBB); send(8'h07);
    wait_idle("rd1", 50);
    drained("rd1");

    for (int unsigned i = 0; i < 3; i++) begin
      rd_q.push_back(4'(4'hE + 4'(i)));
      tx_q.push_back(mem[4'(4'hE + 4'(i))]);
    end
    base = tx_seen;
    send(8'hEE); send(8'h0E); send(8'h03);
    n = 0;
    while (tx_seen == base && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("burst_first_tx", tx_seen - base, 32'd1);
    bus.FIFO_FULL = 1'b1;
    repeat (5) @(negedge clk);
    check("burst_stalled", tx_seen - base, 32'd1);
    bus.FIFO_FULL = 1'b0;
    wait_idle("burst3", 100);
    check("burst_tx_count", tx_seen - base, 32'd3);
    drained("burst3");

    burst("burst8", 4'hC, 8);

    // frame errors: unknown command, count 0, count above BURST_MAX
    ferr_exp++;
    tx_q.push_back(8'hFF);
    send(8'h42);
    check("err_pulse", 32'(bus.Frame_Err), 32'd1);
    wait_idle("err_cmd", 20);
    drained("err_cmd");

    ferr_exp++;
    tx_q.push_back(8'hFF);
    send(8'hEE); send(8'h03); send(8'h00);
    wait_idle("err_cnt0", 20);
    drained("err_cnt0");

    ferr_exp++;
    tx_q.push_back(8'hFF);
    send(8'hEE); send(8'h03); send(8'h09);
    wait_idle("err_cnt9", 20);
    drained("err_cnt9");

    // byte arriving on the last cycle before timeout is accepted
    wr_q.push_back({4'h2, 8'h55});
    send(8'hAA);
    repeat (TMO - 2) @(negedge clk);
    send(8'h02); send(8'h55);
    wait_idle("tmo_edge", 20);
    drained("tmo_edge");

    // silence after the address byte times out without a write
    ferr_exp++;
    tx_q.push_back(8'hFF);
    send(8'hAA); send(8'h02);
    wait_idle("tmo", TMO + 100);
    drained("tmo");

    // reset while stalled in ALU_TX drops the pending result bytes
    bus.FIFO_FULL = 1'b1;
    wr_q.push_back({4'h0, 8'h11});
    wr_q.push_back({4'h1, 8'h22});
    send(8'hCC); send(8'h11); send(8'h22); send(8'h03);
    bus.ALU_OUT   = 16'h1234;
    bus.OUT_Valid = 1'b1;
    @(negedge clk);
    bus.OUT_Valid = 1'b0;
    repeat (3) @(negedge clk);
    check("stall_busy", 32'(bus.Busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_zero("rst_mid");
    rst = 1'b0;
    bus.FIFO_FULL = 1'b0;
    repeat (10) @(negedge clk);
    check("rst_after_idle", 32'(bus.Busy), 32'd0);
    drained("rst_mid");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cmd_frame_ctrl.md
# cmd_frame_ctrl

Parametrised UART command-frame controller: decodes byte frames from the UART RX path, drives register-file write/read and ALU operations, and returns results to the UART TX FIFO. Generalises the current system controller with configurable data/ALU widths, N-byte ALU results, burst register reads, a frame timeout, and error reporting. Sits between UART_RX/TX (via FIFO) and the register file / gated ALU in the CLK (REF) domain.

## Interface
- DATA_WIDTH, 8, UART byte and register-file data width
- ADDR_WIDTH, 4, register-file address width
- ALU_WIDTH, 16, ALU result width; must be a multiple of DATA_WIDTH (RES_BYTES = ALU_WIDTH/DATA_WIDTH)
- ALUFN_WIDTH, 4, ALU function width
- BURST_MAX, 8, max burst-read count
- TIMEOUT_CYCLES, 1023, stall limit in cycles
- ERR_BYTE, 'hFF, byte sent to TX on any frame error
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- RX_P_Data  in  DATA_WIDTH  received byte; RX_D_VLD  in  1  one-cycle valid
- RdData  in  DATA_WIDTH  register-file read data; RdData_Valid  in  1
- ALU_OUT  in  ALU_WIDTH  ALU result; OUT_Valid  in  1
- FIFO_FULL  in  1  TX FIFO full
- Address  out  ADDR_WIDTH; WrEn  out  1; RdEn  out  1; WrData  out  DATA_WIDTH
- ALU_EN  out  1; ALU_FUN  out  ALUFN_WIDTH; CLK_EN  out  1  ALU clock-gate enable
- TX_P_Data  out  DATA_WIDTH; TX_D_VLD  out  1  one-cycle write strobe into TX FIFO
- Busy  out  1  high whenever state is not IDLE
- Frame_Err  out  1  one-cycle pulse on error detection

## Operation
- Commands (first byte in IDLE): 'hAA write {addr, data}; 'hBB read {addr}; 'hCC ALU {A, B, fun}; 'hDD ALU {fun}; 'hEE burst read {addr, count}. Any other byte -> error.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_CNT, RD_REQ, RD_WAIT, RD_TX, ALU_A, ALU_B, ALU_FUN, ALU_WAIT, ALU_TX, ERR_TX.
- Write: addr byte latched (low ADDR_WIDTH bits); data byte -> WrEn=1 for exactly one cycle with latched Address, WrData=data; -> IDLE.
- ALU_A/ALU_B write operand to address 0 / 1 (one-cycle WrEn each). ALU_FUN latches RX_P_Data[ALUFN_WIDTH-1:0] into ALU_FUN; ALU_EN=CLK_EN=1 from that cycle until last result byte is sent.
- ALU_WAIT: first OUT_Valid captures ALU_OUT into result register; ALU_TX sends RES_BYTES bytes LSB first, one per cycle when !FIFO_FULL; then IDLE.
- 'hBB is a burst of count 1. Burst: count of 0 or > BURST_MAX -> error. Per word: RdEn one-cycle pulse (RD_REQ), wait RdData_Valid (RD_WAIT), send byte when !FIFO_FULL (RD_TX), address increments modulo 2^ADDR_WIDTH (wraps 'hF -> 'h0 at default width).
- RX_D_VLD bytes arriving in RD_REQ..RD_TX, ALU_WAIT, ALU_TX, ERR_TX are dropped.
- Timeout counter: cleared on state entry and on every accepted RX byte; counts in receive states (WR_*, RD_ADDR, RD_CNT, ALU_A/B/FUN) and RD_WAIT/ALU_WAIT; not during FIFO_FULL stalls in TX states. At TIMEOUT_CYCLES -> error.
- Error: Frame_Err pulse, go to ERR_TX, send ERR_BYTE once FIFO not full, -> IDLE; ALU_EN/CLK_EN drop.

## Timing
- All outputs registered. Reset (sync, RST=1 at CLK edge): state IDLE, all enables/valids/Busy/Frame_Err 0, Address/WrData/TX_P_Data/ALU_FUN 0, counters 0. Reset mid-frame aborts with no further WrEn/TX.
- RX byte at edge n -> WrEn/RdEn/ALU_FUN update visible after edge n+1 (1-cycle latency).
- RdData_Valid at n -> TX_D_VLD after n+1 if !FIFO_FULL; else held until first cycle FIFO_FULL=0.
- TX_D_VLD never asserted while FIFO_FULL=1 in the same cycle; never two bytes per cycle.
- Timeout and RX_D_VLD in same cycle: byte accepted, no error.

## Test plan
- Write 'hAA,'h05,'h3C -> one WrEn pulse, Address=5, WrData='h3C; Busy low afterwards.
- 'hCC,'h0A,'h03,'h00 with ALU_OUT='h010D -> writes addr0='h0A, addr1='h03, ALU_FUN=0, TX bytes 'h0D then 'h01.
- Burst 'hEE,'h0E,'h03 -> RdEn at addresses 'hE,'hF,'h0; three TX bytes; FIFO_FULL held 5 cycles mid-burst delays but loses nothing.
- Unknown 'h42 and burst count 0 -> Frame_Err pulse, TX ERR_BYTE 'hFF, back to IDLE.
- 'hAA,'h02 then silence TIMEOUT_CYCLES -> Frame_Err, 'hFF sent, no WrEn; RST asserted mid-ALU_TX -> all outputs 0 next cycle.
